// File: rtl/soc_mem_pkg.sv
// Shared definitions for the core-to-data-RAM arbitration slice.
// Provides the default bus geometry, the per-master request bundle type,
// the master index type and small index helpers used by the arbiter.
package soc_mem_pkg;

    localparam int DEF_N_MASTERS  = 2;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;

    // Width of a master index; never collapses to zero bits.
    function automatic int idx_width(input int n);
        int w;
        w = (n > 1) ? $clog2(n) : 1;
        return w;
    endfunction

    localparam int DEF_IDX_WIDTH = idx_width(DEF_N_MASTERS);

    typedef logic [DEF_IDX_WIDTH-1:0] master_idx_t;

    // Request fields a master presents while waiting for its grant.
    typedef struct packed {
        logic                      we;
        logic [DEF_BE_WIDTH-1:0]   be;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    // (base + inc) mod n for base < n and inc <= n. Written as an explicit
    // compare-and-subtract so non-power-of-two master counts wrap correctly.
    function automatic int wrap_add(input int base, input int inc, input int n);
        int sum;
        sum = base + inc;
        if (sum >= n) begin
            sum = sum - n;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/dp_mem_arbiter_if.sv
// Bundle of the core-side request/grant/response signals and the RAM-side
// access port handled by dp_mem_arbiter.
//   slave  : arbiter view (takes core requests and RAM read data, drives
//            grants, responses and the RAM access strobe/fields)
//   master : environment view (cores plus RAM)
interface dp_mem_arbiter_if
    import soc_mem_pkg::*;
#(
    parameter int N_MASTERS  = DEF_N_MASTERS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    localparam int BE_W = DATA_WIDTH / 8;

    // core side
    logic [N_MASTERS-1:0]                 m_req_i;
    logic [N_MASTERS-1:0]                 m_lock_i;
    logic [N_MASTERS-1:0]                 m_we_i;
    logic [N_MASTERS-1:0][BE_W-1:0]       m_be_i;
    logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i;
    logic [N_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i;
    logic [N_MASTERS-1:0]                 m_gnt_o;
    logic [N_MASTERS-1:0]                 m_rvalid_o;
    logic [DATA_WIDTH-1:0]                m_rdata_o;

    // RAM side
    logic                                 mem_req_o;
    logic                                 mem_we_o;
    logic [BE_W-1:0]                      mem_be_o;
    logic [ADDR_WIDTH-1:0]                mem_addr_o;
    logic [DATA_WIDTH-1:0]                mem_wdata_o;
    logic [DATA_WIDTH-1:0]                mem_rdata_i;

    modport slave (
        input  m_req_i, m_lock_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, mem_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output m_req_i, m_lock_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, mem_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/dp_mem_arbiter_rr_prio_sel.sv
// rr_prio_sel: combinational round-robin priority selector.
//   req_i        per-master request vector
//   last_ptr_i   index of the most recently granted master
//   lock_valid_i a master currently holds the lock
//   lock_owner_i index of the lock holder
//   gnt_o        one-hot grant
//   idx_o        granted index (0 when nothing is granted)
//   any_o        a grant is issued
// A requesting lock owner always wins; otherwise the search starts at the
// master after last_ptr_i and wraps around.
module rr_prio_sel
    import soc_mem_pkg::*;
#(
    parameter  int N_MASTERS = DEF_N_MASTERS,
    localparam int IDX_W     = idx_width(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_ptr_i,
    input  logic                 lock_valid_i,
    input  logic [IDX_W-1:0]     lock_owner_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    logic [IDX_W-1:0] cand_s;

    // Pick the winner: lock owner first, else first requester after last_ptr.
    always_comb begin
        idx_o  = '0;
        any_o  = 1'b0;
        cand_s = '0;
        if (lock_valid_i && req_i[lock_owner_i]) begin
            idx_o = lock_owner_i;
            any_o = 1'b1;
        end else begin
            for (int i = 1; i <= N_MASTERS; i++) begin
                cand_s = IDX_W'(wrap_add(int'(last_ptr_i), i, N_MASTERS));
                if (!any_o && req_i[cand_s]) begin
                    idx_o = cand_s;
                    any_o = 1'b1;
                end else begin
                    any_o = any_o;
                end
            end
        end
    end

    // One-hot decode of the winning index.
    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            gnt_o[i] = any_o && (idx_o == IDX_W'(i));
        end
    end

endmodule

// File: rtl/dp_mem_arbiter.sv
// dp_mem_arbiter: shares one single-port data RAM between N core data ports.
//   clk_i  clock, all state on the rising edge
//   rst_i  synchronous active-high reset
//   bus    dp_mem_arbiter_if.slave: core req/lock/we/be/addr/wdata in,
//          one-hot gnt (same cycle) and rvalid (one cycle later) out,
//          shared rdata out; RAM req/we/be/addr/wdata out, RAM rdata in.
// At most one access is granted per cycle. The RAM's 1-cycle response is
// steered back to the master that issued it. A master asserting lock keeps
// the grant for as long as it keeps requesting.
module dp_mem_arbiter
    import soc_mem_pkg::*;
#(
    parameter int N_MASTERS  = DEF_N_MASTERS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic             clk_i,
    input logic             rst_i,
    dp_mem_arbiter_if.slave bus
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = idx_width(N_MASTERS);

    typedef struct packed {
        logic                  we;
        logic [BE_W-1:0]       be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_bundle_t;

    logic [N_MASTERS-1:0] sel_gnt_s;
    logic [IDX_W-1:0]     sel_idx_s;
    logic                 sel_any_s;
    logic                 grant_any_s;
    logic [N_MASTERS-1:0] gnt_s;
    logic [N_MASTERS-1:0] rvalid_s;
    req_bundle_t          mux_s;

    logic [IDX_W-1:0]     last_ptr_r;
    logic                 lock_valid_r;
    logic [IDX_W-1:0]     lock_owner_r;
    logic                 resp_valid_r;
    logic [IDX_W-1:0]     resp_id_r;

    rr_prio_sel #(
        .N_MASTERS (N_MASTERS)
    ) u_sel (
        .req_i        (bus.m_req_i),
        .last_ptr_i   (last_ptr_r),
        .lock_valid_i (lock_valid_r),
        .lock_owner_i (lock_owner_r),
        .gnt_o        (sel_gnt_s),
        .idx_o        (sel_idx_s),
        .any_o        (sel_any_s)
    );

    // Suppress all grants while reset is held, whatever is requested.
    always_comb begin
        grant_any_s = 1'b0;
        gnt_s       = '0;
        if (rst_i) begin
            grant_any_s = 1'b0;
            gnt_s       = '0;
        end else begin
            grant_any_s = sel_any_s;
            gnt_s       = sel_gnt_s;
        end
    end

    // Route the granted master's fields to the RAM; master 0 when idle so
    // the RAM-side fields stay stable.
    always_comb begin
        mux_s.we    = bus.m_we_i[0];
        mux_s.be    = bus.m_be_i[0];
        mux_s.addr  = bus.m_addr_i[0];
        mux_s.wdata = bus.m_wdata_i[0];
        if (grant_any_s) begin
            mux_s.we    = bus.m_we_i[sel_idx_s];
            mux_s.be    = bus.m_be_i[sel_idx_s];
            mux_s.addr  = bus.m_addr_i[sel_idx_s];
            mux_s.wdata = bus.m_wdata_i[sel_idx_s];
        end else begin
            mux_s = mux_s;
        end
    end

    // Pointer, lock and response-tracking state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_ptr_r   <= IDX_W'(N_MASTERS - 1);
            lock_valid_r <= 1'b0;
            lock_owner_r <= '0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= '0;
        end else begin
            resp_valid_r <= grant_any_s;
            resp_id_r    <= sel_idx_s;
            if (grant_any_s) begin
                // A grant re-evaluates the lock: the winner takes it if it
                // asks, and an owner granted without lock lets it go.
                last_ptr_r   <= sel_idx_s;
                lock_valid_r <= bus.m_lock_i[sel_idx_s];
                lock_owner_r <= sel_idx_s;
            end else begin
                // No grant means nobody, including any owner, is requesting.
                last_ptr_r   <= last_ptr_r;
                lock_valid_r <= 1'b0;
                lock_owner_r <= lock_owner_r;
            end
        end
    end

    // Response strobe for the master granted last cycle; a response still
    // in flight when reset arrives is dropped.
    always_comb begin
        rvalid_s = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            rvalid_s[i] = resp_valid_r && !rst_i && (resp_id_r == IDX_W'(i));
        end
    end

    assign bus.m_gnt_o     = gnt_s;
    assign bus.m_rvalid_o  = rvalid_s;
    assign bus.m_rdata_o   = bus.mem_rdata_i;
    assign bus.mem_req_o   = grant_any_s;
    assign bus.mem_we_o    = mux_s.we;
    assign bus.mem_be_o    = mux_s.be;
    assign bus.mem_addr_o  = mux_s.addr;
    assign bus.mem_wdata_o = mux_s.wdata;

endmodule

// File: tb/tb_dp_mem_arbiter.sv
// Directed self-checking bench for dp_mem_arbiter with two masters and a
// small byte-enabled RAM model with one-cycle read latency.
module tb_dp_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cnt0  = 0;
    int   cnt1  = 0;
    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;

    always #5 clk = ~clk;

    dp_mem_arbiter_if #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dp_mem_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // RAM model: 64 words, byte-enabled writes, registered read data.
    logic [31:0] ram [0:63];
    logic [31:0] rd_q = 32'h0;

    always @(posedge clk) begin
        if (bus.mem_req_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be_o[b]) ram[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
                end
            end else begin
                rd_q <= ram[bus.mem_addr_o[7:2]];
            end
        end
    end

    assign bus.mem_rdata_i = rd_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        bus.m_req_i      = 2'b11;
        bus.m_lock_i     = 2'b00;
        bus.m_we_i       = 2'b00;
        bus.m_be_i[0]    = 4'hF;
        bus.m_be_i[1]    = 4'hF;
        bus.m_addr_i[0]  = 32'h100;
        bus.m_addr_i[1]  = 32'h200;
        bus.m_wdata_i[0] = 32'h0;
        bus.m_wdata_i[1] = 32'h0;

        // Reset: no grant, no strobe, no response despite requests.
        tick;
        #1;
        chk("rst_gnt",    64'(bus.m_gnt_o),    64'(2'b00));
        chk("rst_memreq", 64'(bus.mem_req_o),  64'(1'b0));
        chk("rst_rvalid", 64'(bus.m_rvalid_o), 64'(2'b00));

        // Reset priority: master 0 first, then master 1.
        tick;
        rst = 1'b0;
        #1;
        chk("prio_gnt0",  64'(bus.m_gnt_o),    64'(2'b01));
        chk("prio_addr0", 64'(bus.mem_addr_o), 64'(32'h100));
        chk("prio_req0",  64'(bus.mem_req_o),  64'(1'b1));
        tick;
        bus.m_req_i = 2'b10;
        #1;
        chk("prio_rv0",   64'(bus.m_rvalid_o), 64'(2'b01));
        chk("prio_gnt1",  64'(bus.m_gnt_o),    64'(2'b10));
        chk("prio_addr1", 64'(bus.mem_addr_o), 64'(32'h200));
        tick;
        bus.m_req_i = 2'b00;
        #1;
        chk("prio_rv1",   64'(bus.m_rvalid_o), 64'(2'b10));
        chk("prio_idle",  64'(bus.m_gnt_o),    64'(2'b00));

        // Steady round robin with both masters always requesting.
        prev_gnt = 2'b00;
        for (int c = 0; c < 8; c++) begin
            tick;
            bus.m_req_i = 2'b11;
            #1;
            exp_gnt = ((c % 2) == 0) ? 2'b01 : 2'b10;
            chk("rr_gnt", 64'(bus.m_gnt_o),    64'(exp_gnt));
            chk("rr_rv",  64'(bus.m_rvalid_o), 64'(prev_gnt));
            cnt0 += int'(bus.m_gnt_o[0]);
            cnt1 += int'(bus.m_gnt_o[1]);
            prev_gnt = exp_gnt;
        end
        chk("rr_cnt0", 64'(cnt0), 64'(4));
        chk("rr_cnt1", 64'(cnt1), 64'(4));

        // Lock: move the pointer to master 0, then master 1 locks for three
        // accesses, a fourth without lock, then master 0 gets its turn.
        tick;
        bus.m_req_i = 2'b01;
        #1;
        chk("lk_pre", 64'(bus.m_gnt_o), 64'(2'b01));
        tick;
        bus.m_req_i  = 2'b11;
        bus.m_lock_i = 2'b10;
        #1;
        chk("lk_g1", 64'(bus.m_gnt_o), 64'(2'b10));
        tick;
        #1;
        chk("lk_g2", 64'(bus.m_gnt_o), 64'(2'b10));
        tick;
        #1;
        chk("lk_g3", 64'(bus.m_gnt_o), 64'(2'b10));
        tick;
        bus.m_lock_i = 2'b00;
        #1;
        chk("lk_rel", 64'(bus.m_gnt_o), 64'(2'b10));
        tick;
        #1;
        chk("lk_after", 64'(bus.m_gnt_o), 64'(2'b01));

        // Write then read back through master 0.
        tick;
        bus.m_req_i      = 2'b01;
        bus.m_we_i       = 2'b01;
        bus.m_be_i[0]    = 4'hF;
        bus.m_addr_i[0]  = 32'h40;
        bus.m_wdata_i[0] = 32'hDEADBEEF;
        #1;
        chk("wr_gnt",   64'(bus.m_gnt_o),     64'(2'b01));
        chk("wr_we",    64'(bus.mem_we_o),    64'(1'b1));
        chk("wr_addr",  64'(bus.mem_addr_o),  64'(32'h40));
        chk("wr_wdata", 64'(bus.mem_wdata_o), 64'(32'hDEADBEEF));
        tick;
        bus.m_we_i = 2'b00;
        #1;
        chk("wr_rv",   64'(bus.m_rvalid_o), 64'(2'b01));
        chk("rd_gnt",  64'(bus.m_gnt_o),    64'(2'b01));
        chk("rd_we",   64'(bus.mem_we_o),   64'(1'b0));
        tick;
        bus.m_req_i = 2'b00;
        #1;
        chk("rd_rv",    64'(bus.m_rvalid_o), 64'(2'b01));
        chk("rd_rdata", 64'(bus.m_rdata_o),  64'(32'hDEADBEEF));

        // Reset mid-operation: master 1's pending response is dropped.
        tick;
        bus.m_req_i     = 2'b10;
        bus.m_addr_i[1] = 32'h200;
        #1;
        chk("mr_gnt1", 64'(bus.m_gnt_o), 64'(2'b10));
        tick;
        rst         = 1'b1;
        bus.m_req_i = 2'b11;
        #1;
        chk("mr_gnt_rst",  64'(bus.m_gnt_o),    64'(2'b00));
        chk("mr_rv_rst",   64'(bus.m_rvalid_o), 64'(2'b00));
        chk("mr_req_rst",  64'(bus.mem_req_o),  64'(1'b0));
        tick;
        #1;
        chk("mr_gnt_rst2", 64'(bus.m_gnt_o),    64'(2'b00));
        chk("mr_rv_rst2",  64'(bus.m_rvalid_o), 64'(2'b00));
        tick;
        rst = 1'b0;
        #1;
        chk("mr_gnt0",  64'(bus.m_gnt_o),    64'(2'b01));
        chk("mr_rv_no", 64'(bus.m_rvalid_o), 64'(2'b00));

        // Idle for five cycles, then contention goes to master 1.
        tick;
        bus.m_req_i = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_req", 64'(bus.mem_req_o), 64'(1'b0));
            chk("idle_gnt", 64'(bus.m_gnt_o),   64'(2'b00));
            chk("idle_rv",  64'(bus.m_rvalid_o), (i == 0) ? 64'(2'b01) : 64'(2'b00));
            tick;
        end
        bus.m_req_i = 2'b11;
        #1;
        chk("idle_next", 64'(bus.m_gnt_o), 64'(2'b10));
        tick;
        bus.m_req_i = 2'b00;
        #1;
        chk("idle_next_rv", 64'(bus.m_rvalid_o), 64'(2'b10));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
